// File: rtl/ahb_sram_slave_if.sv
// AHB3-Lite signal bundle between one master and the SRAM slave.
// The master modport drives the request side and the slave modport drives the response side.
interface ahb_sram_slave_if;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic [1:0]  HRESP;
  logic [31:0] HRDATA;

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA,
    input  HREADY, HRESP, HRDATA
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA,
    output HREADY, HRESP, HRDATA
  );
endinterface

// File: rtl/ahb_sram_slave.sv
// AHB3-Lite SRAM slave with programmable OKAY wait states and a two-cycle ERROR response.
// Each beat is decoded on its own; the memory itself is never reset.
module ahb_sram_slave #(
  parameter int unsigned MEM_DEPTH   = 256,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic            HCLK,
  input  logic            HRESETn,
  ahb_sram_slave_if.slave bus
);

  localparam int unsigned AW        = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int unsigned BYTES     = MEM_DEPTH * 4;
  localparam logic [2:0]  WAIT_LOAD = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR1 = 2'd2,
    ST_ERR2 = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [2:0]    cnt_q, cnt_d;
  logic          pend_q, pend_d;
  logic          write_q, write_d;
  logic [1:0]    size_q, size_d;
  logic [AW+1:0] addr_q, addr_d;
  logic          hready_q, hready_d;
  logic [1:0]    hresp_q, hresp_d;

  logic          accept;
  logic          legal;
  logic          commit;
  logic [3:0]    lane_en;
  logic [31:0]   mem [MEM_DEPTH];

  logic [2:0]    unused_hburst;
  assign unused_hburst = bus.HBURST;

  // Address-phase decode and next-state logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pend_d   = pend_q;
    write_d  = write_q;
    size_d   = size_q;
    addr_d   = addr_q;

    accept = bus.HSEL && bus.HTRANS[1] && hready_q;
    legal  = (bus.HADDR < 32'(BYTES)) && (bus.HSIZE <= 3'd2) &&
             !((bus.HSIZE == 3'd1) && bus.HADDR[0]) &&
             !((bus.HSIZE == 3'd2) && (bus.HADDR[1:0] != 2'b00));

    // With HREADY high the pending data phase (if any) completes this cycle.
    if (hready_q) pend_d = 1'b0;

    unique case (state_q)
      ST_IDLE, ST_ERR2: begin
        state_d = ST_IDLE;
        if (accept) begin
          addr_d  = bus.HADDR[AW+1:0];
          write_d = bus.HWRITE;
          size_d  = bus.HSIZE[1:0];
          if (!legal) begin
            state_d = ST_ERR1;
          end else begin
            pend_d = 1'b1;
            if (WAIT_STATES != 0) begin
              state_d = ST_WAIT;
              cnt_d   = WAIT_LOAD;
            end
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == 3'd0) state_d = ST_IDLE;
        else               cnt_d   = cnt_q - 3'd1;
      end
      ST_ERR1: state_d = ST_ERR2;
      default: state_d = ST_IDLE;
    endcase

    hready_d = (state_d != ST_WAIT) && (state_d != ST_ERR1);
    hresp_d  = ((state_d == ST_ERR1) || (state_d == ST_ERR2)) ? 2'b01 : 2'b00;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 3'd0;
      pend_q   <= 1'b0;
      write_q  <= 1'b0;
      size_q   <= 2'd0;
      addr_q   <= '0;
      hready_q <= 1'b1;
      hresp_q  <= 2'b00;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pend_q   <= pend_d;
      write_q  <= write_d;
      size_q   <= size_d;
      addr_q   <= addr_d;
      hready_q <= hready_d;
      hresp_q  <= hresp_d;
    end
  end

  // Little-endian byte-lane enables for the pending write.
  always_comb begin
    lane_en = 4'b0000;
    unique case (size_q)
      2'd0:    lane_en[addr_q[1:0]] = 1'b1;
      2'd1:    lane_en = addr_q[1] ? 4'b1100 : 4'b0011;
      default: lane_en = 4'b1111;
    endcase
  end

  assign commit = pend_q && hready_q;

  always_ff @(posedge HCLK) begin
    if (commit && write_q) begin
      for (int i = 0; i < 4; i++) begin
        if (lane_en[i]) mem[addr_q[AW+1:2]][8*i +: 8] <= bus.HWDATA[8*i +: 8];
      end
    end
  end

  // Read data depends only on registered state, never on the live bus inputs.
  assign bus.HRDATA = (commit && !write_q) ? mem[addr_q[AW+1:2]] : 32'h0;
  assign bus.HREADY = hready_q;
  assign bus.HRESP  = hresp_q;

endmodule

// File: doc/ahb_sram_slave.md
# ahb_sram_slave

AHB3-Lite memory slave that sits on the bus side of the agent interface and answers master transfers by driving HREADY, HRESP and HRDATA. It lets the UVM master agent and monitor run against real RTL. It also models programmable wait states and the two-cycle ERROR response, so slave-response paths are exercised without a behavioural slave driver.

## Interface
Parameters:
- MEM_DEPTH, 256: number of 32-bit words. Valid byte addresses are 0 to MEM_DEPTH*4-1.
- WAIT_STATES, 0: HREADY-low cycles inserted in every OKAY data phase. Range 0-7.

Ports:
- HCLK  in  1  bus clock; all state changes on its rising edge
- HRESETn  in  1  reset, asynchronous, active-low
- HSEL  in  1  slave select, qualifies the address phase
- HADDR  in  32  byte address
- HTRANS  in  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11
- HWRITE  in  1  1=write, 0=read
- HSIZE  in  3  0=byte, 1=halfword, 2=word; others illegal
- HBURST  in  3  accepted but not used; every beat is decoded on its own
- HWDATA  in  32  write data, valid in the data phase
- HREADY  out  1  transfer done / bus ready; also sampled internally as the bus HREADY
- HRESP  out  2  OKAY=00, ERROR=01; RETRY and SPLIT are never driven
- HRDATA  out  32  read data

## Operation
**Address-phase acceptance**
- A transfer is accepted on a rising edge where HSEL=1, HTRANS[1]=1 and HREADY=1.
- On acceptance, register HADDR, HWRITE and HSIZE as addr_q, write_q and size_q.
- IDLE or BUSY, or HSEL=0: nothing is accepted. The next cycle is a zero-wait OKAY (HREADY=1, HRESP=00).

**Error check at acceptance.** A transfer is illegal if any of these hold:
- HADDR >= MEM_DEPTH*4
- HSIZE > 2
- misaligned: halfword with HADDR[0]=1, or word with HADDR[1:0]!=0

**State machine: IDLE, WAIT, ERR1, ERR2**
- IDLE: HREADY=1, HRESP=00.
  - Legal accept with WAIT_STATES>0 -> WAIT, counter loaded with WAIT_STATES-1.
  - Legal accept with WAIT_STATES=0 -> stays IDLE, and the data phase completes in the next cycle.
  - Illegal accept -> ERR1.
- WAIT: HREADY=0, HRESP=00. Counter decrements each cycle. When the counter is 0, the next state is IDLE and the data phase completes there.
- ERR1: HREADY=0, HRESP=01. Always -> ERR2.
- ERR2: HREADY=1, HRESP=01. Address-phase acceptance applies exactly as in IDLE, with the same next-state rules.

**Data-phase completion.** Completion is the cycle where a legal data phase is pending and HREADY=1.
- Write: on the completion edge, write HWDATA byte lanes into mem[addr_q>>2].
  - Lane enables come from size_q and addr_q[1:0], little-endian.
  - Byte enables lane addr_q[1:0]. Halfword enables lanes {addr_q[1],0} and {addr_q[1],1}. Word enables all four lanes.
- Read: during the completion cycle, HRDATA = mem[addr_q>>2], the full word with all lanes driven. At all other times HRDATA=0.
- Errored transfers never write memory. HRDATA stays 0 during ERR1 and ERR2.

**Back-to-back transfers**
- Transfers are pipelined: the next address phase overlaps the current completion cycle.
- Write to address A followed immediately by a read of A: the read's data phase is one cycle later than the write commit, so it returns the new data. No forwarding is needed.

**Reset**
- Asserting HRESETn low forces IDLE, HREADY=1, HRESP=00, HRDATA=0 and clears all pending-phase flags.
- Reset mid-transfer aborts the transfer and no write occurs.
- Memory contents are not reset.

## Timing
- Read latency from the accept edge: data valid WAIT_STATES+1 cycles later, in the cycle where HREADY=1.
- A write commits on the edge WAIT_STATES+1 cycles after the accept edge.
- The error response is exactly 2 cycles: {HREADY=0, HRESP=01} then {HREADY=1, HRESP=01}.
- Outputs are registered from state plus addr_q. HRDATA is a combinational read of the memory array using addr_q only; it has no path from the current bus inputs.
- A master changing HTRANS to IDLE during ERR1 has no effect on the ERR2 cycle.
- All outputs take their reset values asynchronously when HRESETn falls.

## Test plan
- **Reset:** assert HRESETn mid-WAIT with WAIT_STATES=3 -> HREADY=1, HRESP=00 and HRDATA=0 immediately; a later read of the target word shows no write occurred.
- **Word round trip:** WAIT_STATES=0; write 0xDEADBEEF to 0x10, then read 0x10 back-to-back -> HRDATA=0xDEADBEEF in the cycle after the read address phase, HRESP=00 throughout.
- **Byte/halfword lanes:**
  - Word write 0x00000000 to 0x20.
  - Byte write 0xAA at 0x21, with HWDATA=0x0000AA00.
  - Halfword write 0x5555 at 0x22, with HWDATA=0x55550000.
  - Word read of 0x20 -> 0x5555AA00.
- **Wait states:** WAIT_STATES=2; read -> HREADY low for exactly 2 cycles, then high with data. A pipelined NONSEQ held during the wait is accepted only on the HREADY=1 edge.
- **Errors:** read of address MEM_DEPTH*4, word write to 0x02, and HSIZE=3 -> each gives the 2-cycle ERROR (01/0 then 01/1); memory is unchanged and HRDATA=0.
- **IDLE/BUSY/HSEL=0:** HTRANS=01 or HSEL=0 with a write -> HREADY=1, HRESP=00, and no memory change.
